// File: rtl/nonogram_stream_parser.sv
// Byte-stream parser for nonogram board descriptions: rebuilds 16-bit tokens, checks grammar, emits BRAM writes and per-line metadata.
// Optional PARSER_CHECKSUM_EN: END_BOARD payload[7:0] must match the XOR of all board bytes.
module nonogram_stream_parser #(
  parameter int MAX_DIM = 32,
  parameter int OPT_AW  = 10,
  parameter int DIM_W   = $clog2(MAX_DIM + 1),
  parameter int CELL_W  = $clog2(MAX_DIM),
  parameter int LINE_W  = $clog2(2 * MAX_DIM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_in,
  input  logic                     valid_in,
  output logic [DIM_W-1:0]         n,
  output logic [DIM_W-1:0]         m,
  output logic                     wr_valid,
  output logic [OPT_AW+CELL_W-1:0] wr_addr,
  output logic [CELL_W:0]          wr_data,
  output logic                     meta_valid,
  output logic [LINE_W-1:0]        meta_line,
  output logic [OPT_AW-1:0]        meta_first_opt,
  output logic [OPT_AW:0]          meta_opt_count,
  output logic                     board_done,
  output logic                     err,
  output logic [2:0]               err_code
);

  localparam int CMP_W = DIM_W + 1;
  localparam logic [12:0] MAX_DIM_P = 13'(MAX_DIM);

  localparam logic [2:0] F_START_BOARD = 3'b111;
  localparam logic [2:0] F_START_LINE  = 3'b110;
  localparam logic [2:0] F_AND         = 3'b101;
  localparam logic [2:0] F_OR          = 3'b010;
  localparam logic [2:0] F_END_LINE    = 3'b001;
  localparam logic [2:0] F_END_BOARD   = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_M, S_BOARD, S_LINE_FIRST, S_LINE, S_DONE, S_ERR
  } state_t;

  state_t state, state_nx;

  logic              phase;
  logic [7:0]        hi_byte;
  logic [OPT_AW-1:0] opt_ptr;
  logic [OPT_AW-1:0] line_base;
  logic [CELL_W:0]   lit_idx;
  logic [LINE_W-1:0] line_idx;
  logic [DIM_W-1:0]  line_len;

  logic              tok_strobe;
  logic [2:0]        flag;
  logic [12:0]       payload;
  logic [CELL_W-1:0] cell_off;
  logic [12:0]       nm_sum;
  logic              lit_full;
  logic              off_bad;
  logic              cs_bad;

  logic       to_err;
  logic [2:0] code_nx;
  logic       do_n, do_m, do_line, do_write, do_next_opt, do_meta, do_done;

  assign tok_strobe = valid_in && phase && (state != S_ERR);
  assign flag       = hi_byte[7:5];
  assign payload    = {hi_byte[4:0], byte_in};
  assign cell_off   = payload[CELL_W:1];
  assign nm_sum     = 13'(n) + 13'(m);
  assign lit_full   = CMP_W'(lit_idx) >= CMP_W'(line_len);
  assign off_bad    = CMP_W'(cell_off) >= CMP_W'(line_len);

`ifdef PARSER_CHECKSUM_EN
  // Running XOR restarts at any high byte seen outside a board; by the END_BOARD
  // low byte it already holds everything through the END_BOARD high byte.
  logic [7:0] csum;
  assign cs_bad = (csum != byte_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
    end else if (valid_in && state != S_ERR) begin
      if (!phase && (state == S_IDLE || state == S_DONE)) csum <= byte_in;
      else                                                csum <= csum ^ byte_in;
    end
  end
`else
  assign cs_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    to_err      = 1'b0;
    code_nx     = 3'd0;
    do_n        = 1'b0;
    do_m        = 1'b0;
    do_line     = 1'b0;
    do_write    = 1'b0;
    do_next_opt = 1'b0;
    do_meta     = 1'b0;
    do_done     = 1'b0;
    if (tok_strobe) begin
      case (state)
        S_IDLE, S_DONE, S_HDR_M: begin
          if (flag != F_START_BOARD) begin
            to_err = 1'b1; code_nx = 3'd1;
          end else if (payload == 13'd0 || payload > MAX_DIM_P) begin
            to_err = 1'b1; code_nx = 3'd2;
          end else if (state == S_HDR_M) begin
            do_m = 1'b1; state_nx = S_BOARD;
          end else begin
            do_n = 1'b1; state_nx = S_HDR_M;
          end
        end
        S_BOARD: begin
          if (flag == F_START_LINE) begin
            if (payload >= nm_sum) begin
              to_err = 1'b1; code_nx = 3'd3;
            end else begin
              do_line = 1'b1; state_nx = S_LINE_FIRST;
            end
          end else if (flag == F_END_BOARD) begin
            if (cs_bad) begin
              to_err = 1'b1; code_nx = 3'd7;
            end else begin
              do_done = 1'b1; state_nx = S_DONE;
            end
          end else begin
            to_err = 1'b1; code_nx = 3'd1;
          end
        end
        S_LINE_FIRST, S_LINE: begin
          if (flag == F_AND) begin
            if (lit_full || off_bad) begin
              to_err = 1'b1; code_nx = 3'd5;
            end else begin
              do_write = 1'b1; state_nx = S_LINE;
            end
          end else if (flag == F_OR || flag == F_END_LINE) begin
            if (state == S_LINE_FIRST) begin
              to_err = 1'b1; code_nx = 3'd4;
            end else if (&opt_ptr) begin
              to_err = 1'b1; code_nx = 3'd6;
            end else begin
              do_next_opt = 1'b1;
              do_meta     = (flag == F_END_LINE);
              state_nx    = (flag == F_END_LINE) ? S_BOARD : S_LINE_FIRST;
            end
          end else begin
            to_err = 1'b1; code_nx = 3'd1;
          end
        end
        default: ;
      endcase
    end
    if (to_err) state_nx = S_ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase          <= 1'b0;
      hi_byte        <= '0;
      opt_ptr        <= '0;
      line_base      <= '0;
      lit_idx        <= '0;
      line_idx       <= '0;
      line_len       <= '0;
      n              <= '0;
      m              <= '0;
      wr_valid       <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      meta_valid     <= 1'b0;
      meta_line      <= '0;
      meta_first_opt <= '0;
      meta_opt_count <= '0;
      board_done     <= 1'b0;
      err            <= 1'b0;
      err_code       <= '0;
    end else begin
      wr_valid   <= 1'b0;
      meta_valid <= 1'b0;
      if (valid_in && state != S_ERR) begin
        phase <= ~phase;
        if (!phase) hi_byte <= byte_in;
      end
      if (do_n) begin
        n          <= payload[DIM_W-1:0];
        board_done <= 1'b0;
        opt_ptr    <= '0;
        lit_idx    <= '0;
      end
      if (do_m) m <= payload[DIM_W-1:0];
      if (do_line) begin
        line_idx  <= payload[LINE_W-1:0];
        line_base <= opt_ptr;
        // rows (index < n) span m cells, columns span n cells
        line_len  <= (payload < 13'(n)) ? m : n;
      end
      if (do_write) begin
        wr_valid <= 1'b1;
        wr_addr  <= {opt_ptr, lit_idx[CELL_W-1:0]};
        wr_data  <= {cell_off, payload[0]};
        lit_idx  <= lit_idx + 1'b1;
      end
      if (do_next_opt) begin
        opt_ptr <= opt_ptr + 1'b1;
        lit_idx <= '0;
      end
      if (do_meta) begin
        meta_valid     <= 1'b1;
        meta_line      <= line_idx;
        meta_first_opt <= line_base;
        meta_opt_count <= {1'b0, opt_ptr} + (OPT_AW+1)'(1) - {1'b0, line_base};
      end
      if (do_done) board_done <= 1'b1;
      if (to_err) begin
        err        <= 1'b1;
        err_code   <= code_nx;
        board_done <= 1'b0;
      end
    end
  end

endmodule

// File: doc/nonogram_stream_parser.md
Name: nonogram_stream_parser

Overview:
- Parametrised board-description parser for the nonogram solver.
- Consumes the UART byte stream, reassembles 16-bit tokens and validates token order against a grammar.
- Writes every literal of every line option into the option BRAM, and emits per-line metadata (first option, option count) for the solver scheduler.
- Supports boards up to MAX_DIM x MAX_DIM, with error detection and reporting.

Parameters:
- MAX_DIM, 32: maximum rows n and columns m.
- OPT_AW, 10: option-pointer width; BRAM holds 2^OPT_AW options.
- DIM_W, $clog2(MAX_DIM+1): width of n/m.
- CELL_W, $clog2(MAX_DIM): width of cell offset and literal index.
- LINE_W, $clog2(2*MAX_DIM): width of the line index.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- byte_in  in  8  stream byte
- valid_in  in  1  byte_in valid this cycle; no backpressure
- n  out  DIM_W  row count
- m  out  DIM_W  column count
- wr_valid  out  1  one-cycle BRAM write strobe
- wr_addr  out  OPT_AW+CELL_W  {opt_ptr, lit_idx}
- wr_data  out  CELL_W+1  {cell offset, value}
- meta_valid  out  1  one-cycle line-metadata strobe
- meta_line  out  LINE_W  line index
- meta_first_opt  out  OPT_AW  first option of the line
- meta_opt_count  out  OPT_AW+1  number of options in the line
- board_done  out  1  level: board parsed cleanly
- err  out  1  sticky error
- err_code  out  3  error cause

Behaviour:
- Reset: rst is synchronous, active-high; clock clk. All outputs reset to 0; state IDLE; byte phase 0; opt_ptr 0; lit_idx 0.
- rst mid-stream aborts the board and discards any half token.

Token assembly:
- Bytes with valid_in=1 alternate phase 0/1, high byte first.
- Token = {hi, lo}; flag = token[15:13]; payload = token[12:0].
- Token is decoded on the cycle the low byte is sampled.
- All outputs register one cycle later.

Flags:
- 111 START_BOARD: payload = dimension.
- 110 START_LINE: payload = line index.
- 101 AND: payload[CELL_W:1] = cell offset, payload[0] = value.
- 010 OR: next option.
- 001 END_LINE.
- 000 END_BOARD.
- 011 and 100 are illegal.

FSM:
- IDLE / DONE: START_BOARD -> n := payload -> HDR_M. In DONE this also clears board_done.
- HDR_M: START_BOARD -> m := payload -> BOARD.
- BOARD: START_LINE -> record line index and line_base := opt_ptr -> LINE_FIRST. END_BOARD -> board_done=1 -> DONE.
- LINE_FIRST / LINE: AND -> write at {opt_ptr, lit_idx}, lit_idx++ -> LINE.
- LINE: OR -> opt_ptr++, lit_idx := 0 -> LINE_FIRST.
- LINE: END_LINE -> opt_ptr++, lit_idx := 0, meta_valid with meta_first_opt = line_base and meta_opt_count = opt_ptr+1-line_base -> BOARD.
- Any other token in any state -> ERR.
- ERR: err=1; all input ignored until rst. No wr_valid or meta_valid is ever issued from ERR.

err_code:
- 1: bad flag or order.
- 2: n or m equal to 0 or greater than MAX_DIM.
- 3: line index >= n+m.
- 4: empty option (OR or END_LINE in LINE_FIRST).
- 5: lit_idx would exceed line length (n for columns, m for rows), or cell offset >= line length.
- 6: opt_ptr would wrap past 2^OPT_AW-1.
- 7: checksum (optional feature).

Checks are made before the write. The offending token produces no write.

Optional Feature:
- Macro PARSER_CHECKSUM_EN.
- When defined: a running XOR of every byte from the first START_BOARD high byte through the END_BOARD high byte is kept. END_BOARD payload[7:0] must equal it. On mismatch: err_code 7, ERR, and board_done is not set.
- When undefined: END_BOARD payload is ignored, and err_code 7 is never produced.

Test Plan:
- 2x2 board, bytes E0 02 E0 02 C0 00 A0 01 A0 02 40 00 A0 00 A0 03 20 00 00 00.
  - Writes: (addr opt0/lit0, data {0,1}), (opt0/lit1, {1,0}), (opt1/lit0, {0,0}), (opt1/lit1, {1,1}).
  - One meta_valid: line 0, first_opt 0, count 2.
  - Then board_done=1, n=m=2.
- Gaps of idle cycles (valid_in=0) between bytes and within tokens -> identical writes, each one cycle after the low byte.
- Header E0 00 -> err=1, err_code=2; no further writes despite following valid tokens.
- START_LINE then 40 00 -> err_code 4. Separately, byte 60 as a flag -> err_code 1.
- rst asserted between the high and low byte of an AND -> outputs 0. A fresh board after rst then parses correctly from opt_ptr 0.
- With PARSER_CHECKSUM_EN defined, a wrong END_BOARD payload -> err_code 7 and board_done stays 0.
